// File: rtl/spu_sm_xmax_pipe.sv
// Running max/argmax over rows of LANES-wide signed beats for the softmax path.
// S1 registers the per-beat comparator tree result; S2 folds it into the row accumulator.
module spu_sm_xmax_pipe #(
    parameter int DW    = 8,
    parameter int LANES = 8,
    parameter int IDXW  = 12
) (
    input  logic                    core_clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DW-1:0]     in_data,
    input  logic [LANES-1:0]        in_mask,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_max,
    output logic [IDXW-1:0]         out_idx,
    output logic                    out_hit
);

    localparam int LW = $clog2(LANES);
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] INIT = {1'b1, {(DW-2){1'b0}}, 1'b1};

    function automatic logic signed [DW-1:0] lane_value(input logic [DW-1:0] raw, input logic en);
        return en ? $signed(raw) : MINV;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (lower lanes) and 2n+2; ties keep the left child.
    logic signed [DW-1:0] node_val  [2*LANES-1];
    logic [LW-1:0]        node_lane [2*LANES-1];

    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        assign node_val[LANES-1+i]  = lane_value(in_data[i*DW +: DW], in_mask[i]);
        assign node_lane[LANES-1+i] = LW'(i);
    end

    for (genvar n = 0; n < LANES-1; n++) begin : g_node
        logic take_right;
        assign take_right   = node_val[2*n+2] > node_val[2*n+1];
        assign node_val[n]  = take_right ? node_val[2*n+2]  : node_val[2*n+1];
        assign node_lane[n] = take_right ? node_lane[2*n+2] : node_lane[2*n+1];
    end

    logic                 vld_p1, last_p1;
    logic signed [DW-1:0] bmax_p1;
    logic [IDXW-1:0]      idx_p1;
    logic [IDXW-1:0]      beat_cnt;
    logic [IDXW-1:0]      idx_calc;
    logic signed [DW-1:0] acc_max;
    logic [IDXW-1:0]      acc_idx;
    logic                 acc_hit;
    logic                 stall, accept, s2_adv, out_en, take;
    logic signed [DW-1:0] m_max;
    logic [IDXW-1:0]      m_idx;
    logic                 m_hit;

    // A finished row parked in S1 blocks intake until the output slot frees up.
    assign stall    = vld_p1 & last_p1 & out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready & ~flush;
    assign idx_calc = (beat_cnt << LW) | IDXW'(node_lane[0]);

    assign s2_adv = vld_p1 & ~stall;
    assign out_en = ~out_valid | out_ready;
    assign take   = bmax_p1 > acc_max;
    assign m_max  = take ? bmax_p1 : acc_max;
    assign m_idx  = take ? idx_p1  : acc_idx;
    assign m_hit  = take | acc_hit;

    // ---- S1: beat reduction register (data path, no reset) ----
    always_ff @(posedge core_clk) begin
        if (!stall) begin
            bmax_p1 <= node_val[0];
            idx_p1  <= idx_calc;
        end
    end

    // ---- S1 control / S2 accumulate / output slot ----
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            beat_cnt  <= '0;
            acc_max   <= INIT;
            acc_idx   <= '0;
            acc_hit   <= 1'b0;
            out_valid <= 1'b0;
            out_max   <= INIT;
            out_idx   <= '0;
            out_hit   <= 1'b0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            beat_cnt  <= '0;
            acc_max   <= INIT;
            acc_idx   <= '0;
            acc_hit   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (!stall) begin
                vld_p1  <= accept;
                last_p1 <= in_last;
            end
            if (accept) begin
                beat_cnt <= in_last ? '0 : beat_cnt + 1'b1;
            end
            if (s2_adv) begin
                if (last_p1) begin
                    acc_max <= INIT;
                    acc_idx <= '0;
                    acc_hit <= 1'b0;
                end else if (take) begin
                    acc_max <= bmax_p1;
                    acc_idx <= idx_p1;
                    acc_hit <= 1'b1;
                end
            end
            if (out_en) begin
                out_valid <= s2_adv & last_p1;
                if (s2_adv & last_p1) begin
                    out_max <= m_max;
                    out_idx <= m_idx;
                    out_hit <= m_hit;
                end
            end
        end
    end

endmodule
